// File: rtl/lm35_adc_reader.sv
// ---------------------------------------------------------------------------
// lm35_adc_reader
//
// Periodically reads an LM35 temperature sensor through a 10-bit SPI ADC
// (mode 0, single-ended channel 0) and converts the raw code to whole
// degrees Celsius: temp = (code * 165) >> 9, which is the code scaled by
// Vref = 3.3 V and the LM35's 10 mV/C slope.
//
// A conversion starts when the free-running sample timer expires or when
// 'start' is pulsed while idle. One frame is:
//   CS_SETUP (CLK_DIV clk) -> SHIFT (16 SCLK periods) -> CS_HOLD (CLK_DIV clk)
//   -> CONVERT (1 clk) -> DONE (1 clk)
// Start-to-valid latency is (2+32)*CLK_DIV + 3 clk cycles.
//
// Parameters
//   CLK_DIV        clk cycles per SCLK half-period (2..255)
//   SAMPLE_PERIOD  clk cycles between automatic conversion starts
//                  (at least 64*CLK_DIV)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   one-cycle request for an immediate conversion
//   adc_miso  in   serial data from the ADC
//   adc_cs_n  out  ADC chip select, active low
//   adc_sclk  out  SPI clock, idle low
//   adc_mosi  out  SPI command bits
//   adc_code  out  last raw 10-bit code captured
//   numero2   out  temperature in whole degrees C (0..329)
//   valid     out  one-cycle strobe when numero2 updates
//   busy      out  high from conversion start until the cycle before valid
//
// Build option
//   LM35_AVG_EN  when defined, numero2/valid update once every four
//                conversions using the mean of the four codes; adc_code
//                still updates on every conversion.
// ---------------------------------------------------------------------------
module lm35_adc_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  output logic [9:0] adc_code,
  output logic [8:0] numero2,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CONVERT,
    DONE
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [31:0] TIMER_LAST = 32'(SAMPLE_PERIOD - 1);
  // start bit, single-ended, channel 0, MSB-first
  localparam logic [3:0]  CMD        = 4'b1101;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  div_cnt;
  logic [4:0]  half_cnt;   // SCLK half-period index inside SHIFT; bit 0 = SCLK level
  logic [31:0] timer;
  logic [9:0]  shreg;
  logic [3:0]  period;     // zero-based SCLK period inside SHIFT
  logic        div_end;
  logic        go;
  logic        shift_en;

`ifdef LM35_AVG_EN
  logic [11:0] acc_sum;
  logic [1:0]  acc_cnt;
`endif

  // Code to degrees C. The 18-bit product cannot overflow (1023*165 < 2^18)
  // and the result truncates toward zero.
  function automatic logic [8:0] to_celsius(input logic [9:0] code);
    logic [17:0] prod;
    prod = 18'(code) * 18'd165;
    return prod[17:9];
  endfunction

  assign div_end = (div_cnt == DIV_LAST);
  assign period  = half_cnt[4:1];
  // Only IDLE can launch a frame, so a start while busy is simply dropped;
  // a start coinciding with timer expiry launches a single frame.
  assign go      = (state == IDLE) && (start || (timer == TIMER_LAST));
  // Sample on the clk where SCLK rises (end of a low half), zero-based
  // periods 5..14; the null bit (period 4) and the final period are skipped.
  assign shift_en = (state == SHIFT) && div_end && !half_cnt[0] &&
                    (period >= 4'd5) && (period <= 4'd14);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    adc_mosi = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_nx = CS_SETUP;
      end
      CS_SETUP: begin
        adc_cs_n = 1'b0;
        if (div_end) state_nx = SHIFT;
      end
      SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = half_cnt[0];
        // MOSI holds for a whole period, so it only moves on SCLK falling
        if (period < 4'd4) adc_mosi = CMD[2'd3 - period[1:0]];
        if (div_end && (half_cnt == 5'd31)) state_nx = CS_HOLD;
      end
      CS_HOLD: begin
        adc_cs_n = 1'b0;
        if (div_end) state_nx = CONVERT;
      end
      CONVERT: begin
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer    <= '0;
      div_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      // The timer runs through the whole frame so that automatic starts are
      // exactly SAMPLE_PERIOD clk apart.
      if (go || (timer == TIMER_LAST)) timer <= '0;
      else                             timer <= timer + 32'd1;

      if ((state == IDLE) || (state == CONVERT) || (state == DONE) || div_end)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 8'd1;

      if (state != SHIFT)  half_cnt <= '0;
      else if (div_end)    half_cnt <= half_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {shreg[8:0], adc_miso};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_code <= '0;
      numero2  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
`ifdef LM35_AVG_EN
      acc_sum  <= '0;
      acc_cnt  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (go) busy <= 1'b1;

      if (state == CONVERT) begin
        adc_code <= shreg;
`ifdef LM35_AVG_EN
        acc_sum  <= acc_sum + 12'(shreg);
        acc_cnt  <= acc_cnt + 2'd1;
`endif
      end

      if (state == DONE) begin
        busy <= 1'b0;
`ifdef LM35_AVG_EN
        // acc_cnt wraps to zero exactly when the fourth code has been added
        if (acc_cnt == 2'd0) begin
          numero2 <= to_celsius(acc_sum[11:2]);
          valid   <= 1'b1;
          acc_sum <= '0;
        end
`else
        numero2 <= to_celsius(adc_code);
        valid   <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lm35_adc_reader.sv
module tb_lm35_adc_reader;

  localparam int CD  = 4;
  localparam int SP  = 4000;
  localparam int LAT = (2 + 32) * CD + 3;
`ifdef LM35_AVG_EN
  localparam int AVG_N = 4;
`else
  localparam int AVG_N = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       adc_miso;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_mosi;
  logic [9:0] adc_code;
  logic [8:0] numero2;
  logic       valid;
  logic       busy;

  lm35_adc_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .adc_miso (adc_miso),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .adc_mosi (adc_mosi),
    .adc_code (adc_code),
    .numero2  (numero2),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] code;
    logic [8:0] temp;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] adc_q[$];
  int         frame_starts[$];
  exp_t       e_m;

  int total = 0, passed = 0;
  int vcount = 0, frames = 0, proto_err = 0, rise_cnt = 0;
  int last_valid_cyc = 0, start_cyc = 0;
  int m_sum = 0, m_n = 0;
  logic [9:0]  cur_code = '0;
  logic [15:0] mosi_bits = '0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  bit   abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int ref_temp(input int c);
    return (c * 165) / 512;
  endfunction

  // ADC model: bit for the next rising edge is presented after the previous one
  function automatic logic miso_bit(input int r, input logic [9:0] c);
    if (r >= 5 && r <= 14) return c[4'(14 - r)];
    return 1'b0;
  endfunction

  always_comb adc_miso = miso_bit(rise_cnt, cur_code);

  // Monitor: scoreboard pop on valid, frame bookkeeping, SPI protocol checks
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) check("valid_expected", 0, 1);
      else begin
        e_m = exp_q.pop_front();
        check("sb_numero2", 32'(numero2), 32'(e_m.temp));
        check("sb_adc_code", 32'(adc_code), 32'(e_m.code));
      end
    end
    if (prev_cs && (adc_cs_n === 1'b0)) begin
      frames++;
      frame_starts.push_back(cyc);
      rise_cnt  = 0;
      mosi_bits = '0;
      if (adc_q.size() == 0) begin
        check("frame_expected", 0, 1);
        cur_code = '0;
      end else cur_code = adc_q.pop_front();
    end
    if (!prev_cs && (adc_cs_n === 1'b1) && !abort) begin
      check("frame_rises", rise_cnt, 16);
      check("frame_mosi", 32'(mosi_bits), 32'h0000_D000);
    end
    if (!prev_sclk && (adc_sclk === 1'b1)) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[14:0], adc_mosi};
    end
    if (prev_sclk && (adc_sclk === 1'b1) && (adc_mosi !== prev_mosi)) proto_err++;
    if ((adc_cs_n === 1'b1) && (adc_sclk !== 1'b0)) proto_err++;
    prev_cs   = (adc_cs_n === 1'b1);
    prev_sclk = (adc_sclk === 1'b1);
    prev_mosi = adc_mosi;
  end

  task automatic push_model(input logic [9:0] code);
    exp_t e;
    adc_q.push_back(code);
    if (AVG_N == 4) begin
      m_sum += int'(code);
      m_n++;
      if (m_n == 4) begin
        e.code = code;
        e.temp = 9'(ref_temp(m_sum / 4));
        exp_q.push_back(e);
        m_sum = 0;
        m_n   = 0;
      end
    end else begin
      e.code = code;
      e.temp = 9'(ref_temp(int'(code)));
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("busy_timeout", 0, 1);
  endtask

  task automatic conv(input logic [9:0] code);
    push_model(code);
    pulse_start();
    wait_idle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int v0, f0, fs0, n;
    logic [9:0] thr[4];
    logic [9:0] avg_codes[4];
    thr       = '{10'd31, 10'd32, 10'd93, 10'd94};
    avg_codes = '{10'd90, 10'd92, 10'd94, 10'd96};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(adc_cs_n), 1);
    check("rst_sclk", 32'(adc_sclk), 0);
    check("rst_mosi", 32'(adc_mosi), 0);
    check("rst_adc_code", 32'(adc_code), 0);
    check("rst_numero2", 32'(numero2), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-scale code
    v0 = vcount;
    for (int i = 0; i < AVG_N; i++) conv(10'h3FF);
    check("latency", 32'(last_valid_cyc - start_cyc), LAT);
    check("valid_cnt_fullscale", 32'(vcount - v0), 1);
    check("numero2_fullscale", 32'(numero2), 329);

    // Display threshold codes
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < AVG_N; i++) conv(thr[k]);
    check("numero2_94", 32'(numero2), 30);

    // Start while busy is dropped
    f0 = frames;
    v0 = vcount;
    for (int i = 0; i < AVG_N - 1; i++) conv(10'd200);
    push_model(10'd200);
    pulse_start();
    repeat (20) @(negedge clk);
    check("busy_mid_frame", 32'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (200) @(negedge clk);
    check("frames_busy_start", 32'(frames - f0), AVG_N);
    check("valids_busy_start", 32'(vcount - v0), 1);
    fs0 = frame_starts.size() - 1;

    // Automatic conversions, no start
    push_model(10'd100);
    push_model(10'd101);
    n = 0;
    while ((frame_starts.size() < fs0 + 3 || busy === 1'b1) && n < 9000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 9000) check("auto_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("auto_period_1", 32'(frame_starts[fs0 + 1] - frame_starts[fs0]), SP);
    check("auto_period_2", 32'(frame_starts[fs0 + 2] - frame_starts[fs0 + 1]), SP);

    // Reset during SCLK period 8
    adc_q.push_back(10'd300);
    pulse_start();
    n = 0;
    while (rise_cnt != 8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("period8_timeout", 0, 1);
    abort = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs_n", 32'(adc_cs_n), 1);
    check("abort_sclk", 32'(adc_sclk), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_numero2", 32'(numero2), 0);
    check("abort_valid", 32'(valid), 0);
    v0 = vcount;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_sum = 0;
    m_n   = 0;
    repeat (300) @(negedge clk);
    check("abort_no_valid", 32'(vcount - v0), 0);
    abort = 1'b0;

    // Four-code sequence (averaged when enabled)
    v0 = vcount;
    for (int k = 0; k < 4; k++) conv(avg_codes[k]);
    check("avg_valid_cnt", 32'(vcount - v0), (AVG_N == 4) ? 1 : 4);
    check("avg_numero2", 32'(numero2), (AVG_N == 4) ? 29 : 30);
    check("avg_adc_code", 32'(adc_code), 96);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);
    check("adc_q_drained", 32'(adc_q.size()), 0);
    check("spi_protocol", 32'(proto_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lm35_adc_reader.md
LM35_ADC_READER -- requirements
Module: lm35_adc_reader

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter SAMPLE_PERIOD, default 5_000_000: clk cycles between automatic conversion starts; minimum 64*CLK_DIV.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request for an immediate conversion.
REQ-006 adc_miso  input  1  serial data from the 10-bit SPI ADC.
REQ-007 adc_cs_n  output  1  ADC chip select, active low.
REQ-008 adc_sclk  output  1  SPI clock, idle low (mode 0).
REQ-009 adc_mosi  output  1  SPI command bits to the ADC.
REQ-010 adc_code  output  10  last raw ADC code captured.
REQ-011 numero2  output  9  temperature in whole degrees C, for the LED and LCD display blocks.
REQ-012 valid  output  1  one-cycle strobe when numero2 updates.
REQ-013 busy  output  1  high from conversion start until the cycle before valid.

Function
REQ-014 FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, CONVERT, DONE.
REQ-015 IDLE: free-running timer counts clk; a conversion starts when timer = SAMPLE_PERIOD-1 or start=1; the timer reloads to 0 on every conversion start.
REQ-016 start while busy=1 is ignored, not queued; start coinciding with timer expiry starts exactly one conversion.
REQ-017 CS_SETUP: adc_cs_n=0 for CLK_DIV cycles with adc_sclk low, then SHIFT.
REQ-018 SHIFT: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 adc_mosi changes only while SCLK is low: 1,1,0,1 (start, single-ended, channel 0, MSB-first) on SCLK periods 1-4, then 0.
REQ-020 adc_miso is sampled on the clk where SCLK rises in periods 6-15, MSB first, into a 10-bit shift register; periods 5 and 16 are ignored.
REQ-021 CS_HOLD: SCLK low, adc_cs_n stays low for CLK_DIV cycles, then goes high; go to CONVERT.
REQ-022 CONVERT, 1 cycle: adc_code <= captured code; temp = (code*165)>>9 (Vref 3.3 V, LM35 10 mV/C), truncated, max 329, fits 9 bits; 18-bit product, no overflow.
REQ-023 DONE, 1 cycle: numero2 <= temp, valid=1, busy=0; next state IDLE.
REQ-024 Latency start->valid = (2+32)*CLK_DIV + 3 clk cycles.
REQ-025 numero2 and adc_code hold their values between updates; adc_cs_n is high in IDLE and DONE.

Reset
REQ-026 rst_n=0 at a clk edge forces: state IDLE, timer 0, adc_cs_n=1, adc_sclk=0, adc_mosi=0, adc_code=0, numero2=0, valid=0, busy=0, and clears the accumulator and count.
REQ-027 Reset mid-frame aborts it at once with adc_cs_n high next cycle; no valid pulse and no partial update.

Configuration
REQ-028 Macro LM35_AVG_EN defined: four consecutive codes accumulate in a 12-bit sum; valid and numero2 update only after the 4th, using code=sum>>2, then the sum clears; adc_code still updates every conversion.
REQ-029 LM35_AVG_EN undefined: no accumulator; every conversion updates numero2 and pulses valid.

Verification
REQ-030 ADC model returns 0x3FF, start pulse -> frame of 16 SCLK with MOSI 1101, adc_code=0x3FF, numero2=329, one valid, latency per REQ-024.
REQ-031 Codes 31, 32, 93, 94 -> numero2 9, 10, 29, 30 (display color thresholds).
REQ-032 No start, SAMPLE_PERIOD=4000, CLK_DIV=4 -> conversions start exactly 4000 clk apart; start while busy -> no extra frame.
REQ-033 rst_n low during SCLK period 8 -> adc_cs_n=1, busy=0 next cycle, numero2 unchanged at 0, no valid.
REQ-034 LM35_AVG_EN, codes 90,92,94,96 -> single valid after 4th frame, numero2=(93*165)>>9=29.
REQ-035 Check throughout: adc_mosi stable while adc_sclk high; adc_sclk low whenever adc_cs_n is high.
